// File: rtl/mul_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mul_ctrl_pkg
//   Shared definitions for the shared-multiplier controller:
//     - state_e     : controller FSM encoding (IDLE / CALC / DONE)
//     - OWNER_REQ0/1: identifiers of the two requesters (also used as the
//                     round-robin pointer value)
//     - CNT_W       : width of the multicycle countdown (covers 1..15 cycles)
// -----------------------------------------------------------------------------
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OWNER_REQ0 = 1'b0;
  localparam logic OWNER_REQ1 = 1'b1;

  localparam int CNT_W = 4;

endpackage : mul_ctrl_pkg

// File: rtl/mul_tree32.sv
// -----------------------------------------------------------------------------
// mul_tree32
//   Purely combinational 32x32 signed multiplier returning the low 32 bits of
//   the two's-complement product. It is intended to be fed from stable
//   registers and sampled as a multicycle path.
// Ports
//   a        in  32  multiplicand (signed)
//   b        in  32  multiplier (signed)
//   product  out 32  low 32 bits of a*b (wraps on overflow)
// -----------------------------------------------------------------------------
module mul_tree32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] product
);

  // The low half of a product is identical for signed and unsigned operands,
  // so a 32-bit result width is sufficient; operands are still treated as
  // signed to document intent.
  assign product = $signed(a) * $signed(b);

endmodule : mul_tree32

// File: rtl/mul_share_ctrl.sv
// -----------------------------------------------------------------------------
// mul_share_ctrl
//   Shares one combinational multiplier (mul_tree32) between two requesters
//   with round-robin arbitration. Operands are captured on acceptance and held
//   for MUL_CYCLES cycles while the tree settles; the truncated product is then
//   registered on the owner's response channel until it is consumed.
// Parameters
//   MUL_CYCLES  cycles allotted to the multiplier tree (1..15)
//   TAG_W       width of the opaque tag echoed request -> response
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready           request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_tag   operands and tag of requester N
//   rspN_valid/ready           response handshake for requester N
//   rspN_result, rspN_tag      registered result and tag for requester N
//   busy                       high whenever an operation is in flight
// -----------------------------------------------------------------------------
module mul_share_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_result,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_result,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic               owner_q, owner_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [31:0]        res0_q, res0_d;
  logic [31:0]        res1_q, res1_d;
  logic [TAG_W-1:0]   rtag0_q, rtag0_d;
  logic [TAG_W-1:0]   rtag1_q, rtag1_d;

  logic               grant_vld;
  logic               grant;
  logic               accept;
  logic               owner_rsp_ready;
  logic [31:0]        product;

  // The tree only ever sees the operand registers, never the request ports.
  mul_tree32 u_tree (
    .a       (a_q),
    .b       (b_q),
    .product (product)
  );

  // Round-robin arbitration: the pointer only breaks ties.
  always_comb begin
    grant_vld = 1'b0;
    grant     = OWNER_REQ0;
    if (req0_valid && req1_valid) begin
      grant_vld = 1'b1;
      grant     = rr_ptr_q;
    end else if (req0_valid) begin
      grant_vld = 1'b1;
      grant     = OWNER_REQ0;
    end else if (req1_valid) begin
      grant_vld = 1'b1;
      grant     = OWNER_REQ1;
    end else begin
      grant_vld = 1'b0;
      grant     = OWNER_REQ0;
    end
  end

  // Handshake and response-channel decode. Ready is gated by rst_n so that
  // nothing is accepted while reset is held, even though the FSM is in IDLE.
  always_comb begin
    accept          = rst_n && (state_q == ST_IDLE) && grant_vld;
    req0_ready      = accept && (grant == OWNER_REQ0);
    req1_ready      = accept && (grant == OWNER_REQ1);
    rsp0_valid      = (state_q == ST_DONE) && (owner_q == OWNER_REQ0);
    rsp1_valid      = (state_q == ST_DONE) && (owner_q == OWNER_REQ1);
    owner_rsp_ready = (owner_q == OWNER_REQ1) ? rsp1_ready : rsp0_ready;
    busy            = (state_q != ST_IDLE);
    rsp0_result     = res0_q;
    rsp0_tag        = rtag0_q;
    rsp1_result     = res1_q;
    rsp1_tag        = rtag1_q;
  end

  // FSM next-state, operand capture, countdown and result loading.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    tag_d    = tag_q;
    res0_d   = res0_q;
    res1_d   = res1_q;
    rtag0_d  = rtag0_q;
    rtag1_d  = rtag1_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d  = grant;
          rr_ptr_d = ~grant;
          cnt_d    = CNT_LOAD;
          a_d      = (grant == OWNER_REQ1) ? req1_a   : req0_a;
          b_d      = (grant == OWNER_REQ1) ? req1_b   : req0_b;
          tag_d    = (grant == OWNER_REQ1) ? req1_tag : req0_tag;
          state_d  = ST_CALC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          // Results are kept per channel so an idle channel holds its value.
          if (owner_q == OWNER_REQ1) begin
            res1_d  = product;
            rtag1_d = tag_q;
          end else begin
            res0_d  = product;
            rtag0_d = tag_q;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (owner_rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      rr_ptr_q <= OWNER_REQ0;
      owner_q  <= OWNER_REQ0;
      a_q      <= 32'h0000_0000;
      b_q      <= 32'h0000_0000;
      tag_q    <= {TAG_W{1'b0}};
      res0_q   <= 32'h0000_0000;
      res1_q   <= 32'h0000_0000;
      rtag0_q  <= {TAG_W{1'b0}};
      rtag1_q  <= {TAG_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tag_q    <= tag_d;
      res0_q   <= res0_d;
      res1_q   <= res1_d;
      rtag0_q  <= rtag0_d;
      rtag1_q  <= rtag1_d;
    end
  end

endmodule : mul_share_ctrl
